// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory and
// presents {pc, pc+4, instr, valid}. Optional IF_INSTR_COUNT_EN adds a saturating issue counter.
module instr_fetch #(
   parameter int                  DATA_BUS    = 32,
   parameter int                  IMEM_LENGTH = 256,
   parameter logic [DATA_BUS-1:0] HALT_INSTR  = 32'hFC000000,
   localparam int                 AW          = $clog2(IMEM_LENGTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_enable,
   input  logic                i_stall,
   input  logic                i_branch_taken,
   input  logic [DATA_BUS-1:0] i_branch_target,
   output logic [AW-1:0]       o_imem_addr,
   input  logic [DATA_BUS-1:0] i_imem_data,
   output logic [DATA_BUS-1:0] o_pc,
   output logic [DATA_BUS-1:0] o_pc_plus4,
   output logic [DATA_BUS-1:0] o_instr,
   output logic                o_valid,
`ifdef IF_INSTR_COUNT_EN
   output logic [31:0]         o_instr_count,
`endif
   output logic                o_halt,
   output logic                o_misaligned
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   state_t              state_q;
   logic [DATA_BUS-1:0] pc_q;
   logic [DATA_BUS-1:0] pc_d;
   logic                primed_q;
   logic                halt_q;
   logic                misaligned_q;

   logic                run_s;
   logic                valid_s;
   logic                halt_hit_s;
   logic                misalign_s;
   logic [DATA_BUS-1:0] pc_inc_s;

   // Next-PC selection; the memory address is taken from pc_d so data lines up with pc_q.
   always_comb begin
      run_s      = (state_q == ST_RUN);
      valid_s    = primed_q && run_s && i_enable && !i_stall && !i_branch_taken;
      halt_hit_s = valid_s && (i_imem_data == HALT_INSTR);
      misalign_s = primed_q && run_s && i_branch_taken && (i_branch_target[1:0] != 2'b00);
      pc_inc_s   = pc_q + DATA_BUS'(4);
      pc_d       = pc_q;
      if (rst) begin
         pc_d = '0;
      end else if (!primed_q || !run_s) begin
         pc_d = pc_q;
      end else if (i_branch_taken) begin
         pc_d = misalign_s ? pc_q : i_branch_target;
      end else if (i_stall || !i_enable) begin
         pc_d = pc_q;
      end else if (halt_hit_s) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_inc_s;
      end
   end

   assign o_imem_addr  = pc_d[AW+1:2];
   assign o_pc         = pc_q;
   assign o_pc_plus4   = pc_inc_s;
   assign o_valid      = valid_s;
   // A stalled instruction stays visible; bubbles, kills and stopped states show a NOP.
   assign o_instr      = (primed_q && run_s && !i_branch_taken) ? i_imem_data : '0;
   assign o_halt       = halt_q;
   assign o_misaligned = misaligned_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= '0;
         primed_q     <= 1'b0;
         state_q      <= ST_RUN;
         halt_q       <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         primed_q <= 1'b1;
         case (state_q)
            ST_RUN: begin
               if (misalign_s) begin
                  state_q      <= ST_FAULT;
                  misaligned_q <= 1'b1;
               end else if (halt_hit_s) begin
                  state_q <= ST_HALTED;
                  halt_q  <= 1'b1;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_HALTED: state_q <= ST_HALTED;
            ST_FAULT:  state_q <= ST_FAULT;
            // An illegal encoding is treated as a fault so fetch stops safely.
            default: begin
               state_q      <= ST_FAULT;
               misaligned_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef IF_INSTR_COUNT_EN
   logic [31:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 32'd0;
      end else if (valid_s && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end else begin
         count_q <= count_q;
      end
   end

   assign o_instr_count = count_q;
`else
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural 1-cycle synchronous instruction memory.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_enable;
   logic        i_stall;
   logic        i_branch_taken;
   logic [31:0] i_branch_target;
   logic [7:0]  o_imem_addr;
   logic [31:0] i_imem_data;
   logic [31:0] o_pc;
   logic [31:0] o_pc_plus4;
   logic [31:0] o_instr;
   logic        o_valid;
   logic        o_halt;
   logic        o_misaligned;
`ifdef IF_INSTR_COUNT_EN
   logic [31:0] o_instr_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   // Memory model: clears its output on reset, otherwise registers the addressed word.
   always @(posedge clk) begin
      if (rst) i_imem_data <= 32'd0;
      else     i_imem_data <= mem[o_imem_addr];
   end

   instr_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .i_enable        (i_enable),
      .i_stall         (i_stall),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .o_imem_addr     (o_imem_addr),
      .i_imem_data     (i_imem_data),
      .o_pc            (o_pc),
      .o_pc_plus4      (o_pc_plus4),
      .o_instr         (o_instr),
      .o_valid         (o_valid),
`ifdef IF_INSTR_COUNT_EN
      .o_instr_count   (o_instr_count),
`endif
      .o_halt          (o_halt),
      .o_misaligned    (o_misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
   endtask

   task automatic chk_issue(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, "_pc"}, o_pc, pc);
      chk({tag, "_pc4"}, o_pc_plus4, pc + 32'd4);
      chk({tag, "_instr"}, o_instr, instr);
      chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
      rst = 1'b0; i_enable = 1'b1; i_stall = 1'b0;
      i_branch_taken = 1'b0; i_branch_target = 32'd0;

      // Sequential fetch after reset
      do_reset();
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_instr", o_instr, 32'd0);
      chk("rst_pc", o_pc, 32'd0);
      chk("rst_halt", {31'd0, o_halt}, 32'd0);
      chk("rst_mis", {31'd0, o_misaligned}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk_issue("seq", 32'(4 * i), 32'h1000 + 32'(i));
      end

      // Stall at pc 8
      do_reset();
      cyc(); cyc(); cyc();
      chk_issue("pre_stall", 32'd8, 32'h1002);
      i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_valid", {31'd0, o_valid}, 32'd0);
         chk("stall_instr", o_instr, 32'h1002);
         chk("stall_addr", {24'd0, o_imem_addr}, 32'd2);
         chk("stall_pc", o_pc, 32'd8);
         if (i < 2) cyc();
      end
      i_stall = 1'b0;
      #1;
      chk_issue("unstall", 32'd8, 32'h1002);
      cyc();
      chk_issue("after_stall", 32'd12, 32'h1003);

      // Branch from pc 12 to 0x40
      i_branch_taken = 1'b1; i_branch_target = 32'h40;
      #1;
      chk("br_kill_valid", {31'd0, o_valid}, 32'd0);
      chk("br_kill_instr", o_instr, 32'd0);
      chk("br_addr", {24'd0, o_imem_addr}, 32'h10);
      cyc();
      i_branch_taken = 1'b0;
      #1;
      chk_issue("br_target", 32'h40, 32'h1010);
      cyc();
      chk_issue("br_next", 32'h44, 32'h1011);

      // Stall together with branch: branch wins
      i_stall = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h80;
      #1;
      chk("stbr_valid", {31'd0, o_valid}, 32'd0);
      cyc();
      i_stall = 1'b0; i_branch_taken = 1'b0;
      #1;
      chk_issue("stbr_target", 32'h80, 32'h1020);

      // Branch to the top of the address space: pc+4 and the word address wrap
      i_branch_taken = 1'b1; i_branch_target = 32'hFFFF_FFFC;
      cyc();
      i_branch_taken = 1'b0;
      #1;
      chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", o_pc_plus4, 32'd0);
      chk("wrap_instr", o_instr, 32'h10FF);
      chk("wrap_addr", {24'd0, o_imem_addr}, 32'd0);
      cyc();
      chk_issue("wrap_next", 32'd0, 32'h1000);

      // Misaligned target from pc 12
      do_reset();
      cyc(); cyc(); cyc(); cyc();
      chk_issue("pre_mis", 32'd12, 32'h1003);
      i_branch_taken = 1'b1; i_branch_target = 32'h42;
      #1;
      chk("mis_cyc_valid", {31'd0, o_valid}, 32'd0);
      cyc();
      i_branch_target = 32'h80;
      #1;
      chk("mis_flag", {31'd0, o_misaligned}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         chk("mis_pc", o_pc, 32'd12);
         chk("mis_valid", {31'd0, o_valid}, 32'd0);
         cyc();
      end
      chk("mis_sticky", {31'd0, o_misaligned}, 32'd1);
      i_branch_taken = 1'b0;
      do_reset();
      chk("mis_clr", {31'd0, o_misaligned}, 32'd0);
      chk("mis_rst_pc", o_pc, 32'd0);
      chk("mis_rst_valid", {31'd0, o_valid}, 32'd0);
      cyc();
      chk_issue("mis_restart", 32'd0, 32'h1000);

      // Reset together with a misaligned branch: reset wins, no fault
      cyc();
      rst = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h42;
      cyc();
      rst = 1'b0; i_branch_taken = 1'b0;
      #1;
      chk("rstbr_mis", {31'd0, o_misaligned}, 32'd0);
      chk("rstbr_pc", o_pc, 32'd0);
      chk("rstbr_valid", {31'd0, o_valid}, 32'd0);
      cyc();
      chk_issue("rstbr_first", 32'd0, 32'h1000);
      chk("rstbr_mis2", {31'd0, o_misaligned}, 32'd0);

      // HALT at word 5
      mem[5] = 32'hFC00_0000;
      do_reset();
      for (int i = 0; i < 6; i++) cyc();
      chk_issue("halt_issue", 32'd20, 32'hFC00_0000);
      chk("halt_pre", {31'd0, o_halt}, 32'd0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("halt_flag", {31'd0, o_halt}, 32'd1);
         chk("halt_valid", {31'd0, o_valid}, 32'd0);
         chk("halt_pc", o_pc, 32'd20);
         chk("halt_instr", o_instr, 32'd0);
`ifdef IF_INSTR_COUNT_EN
         chk("halt_count", o_instr_count, 32'd6);
`endif
         i_branch_taken = (i == 1);
         i_branch_target = 32'h40;
         cyc();
      end
      i_branch_taken = 1'b0;

      // Branch in the HALT cycle kills the HALT
      do_reset();
      for (int i = 0; i < 6; i++) cyc();
      i_branch_taken = 1'b1; i_branch_target = 32'h40;
      #1;
      chk("hbr_valid", {31'd0, o_valid}, 32'd0);
      cyc();
      i_branch_taken = 1'b0;
      #1;
      chk("hbr_halt", {31'd0, o_halt}, 32'd0);
      chk_issue("hbr_target", 32'h40, 32'h1010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
